multicycle_ctrl: RTL and testbench

- Multi-cycle sequencing FSM for the MIPS-style datapath (PC, instruction/data memory, register file, ALU, sign-extend).
- Replaces the single-cycle control unit: one instruction is split into fetch, decode, execute, memory and writeback steps, so ALU and memory are shared across cycles.
- Adds a memory ready handshake, an illegal-opcode halt and a retired-instruction counter.

---
 rtl/mc_pkg.sv | 58 +++++
 rtl/mc_out_decode.sv | 73 +++++++
 rtl/multicycle_ctrl.sv | 116 +++++++++++
 tb/tb_multicycle_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes, mux codes
// and the packed control word produced by the state decoder.
package mc_pkg;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StRwb    = 4'd7,
        StBranch = 4'd8,
        StJump   = 4'd9,
        StAddiEx = 4'd10,
        StAddiWb = 4'd11,
        StHalt   = 4'd12
    } state_e;

    localparam logic [5:0] OpR    = 6'b000000;
    localparam logic [5:0] OpLw   = 6'b100011;
    localparam logic [5:0] OpSw   = 6'b101011;
    localparam logic [5:0] OpBeq  = 6'b000100;
    localparam logic [5:0] OpJ    = 6'b000010;
    localparam logic [5:0] OpAddi = 6'b001000;

    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluFunct = 2'b10;

    localparam logic [1:0] PcAlu    = 2'b00;
    localparam logic [1:0] PcAluOut = 2'b01;
    localparam logic [1:0] PcJump   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/mc_out_decode.sv
// Combinational state-to-control-word decoder. Only FETCH looks at mem_ready, to hold
// off the PC and IR loads until the instruction word is actually there.
module mc_out_decode
    import mc_pkg::*;
(
    input  state_e state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            StFetch: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SrcBFour;
                ctrl.alu_op    = AluAdd;
                ctrl.pc_src    = PcAlu;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            StDecode: begin
                ctrl.alu_src_b = SrcBImmSh;
                ctrl.alu_op    = AluAdd;
            end
            StMemAdr, StAddiEx: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SrcBImm;
                ctrl.alu_op    = AluAdd;
            end
            StMemRd: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            StMemWb: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            StMemWr: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            StExec: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SrcBReg;
                ctrl.alu_op    = AluFunct;
            end
            StRwb: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            StBranch: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SrcBReg;
                ctrl.alu_op        = AluSub;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = PcAluOut;
            end
            StJump: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PcJump;
            end
            StAddiWb: begin
                ctrl.reg_write = 1'b1;
            end
            StHalt: begin
                ctrl.halted = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing FSM for the MIPS datapath, with memory ready handshake,
// illegal-opcode halt and a retired-instruction counter.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter bit          MEM_WAIT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zf,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             halted,
    output logic [3:0]       state_dbg,
    output logic [CNT_W-1:0] instr_count
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q;
    logic             retire;
    logic             ready;
    ctrl_t            ctrl_raw, ctrl;

    // zf only qualifies pc_write_cond inside the datapath.
    logic unused_zf;
    assign unused_zf = zf;

    assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            StFetch:  if (ready) state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpR:        state_d = StExec;
                    OpBeq:      state_d = StBranch;
                    OpJ:        state_d = StJump;
                    OpAddi:     state_d = StAddiEx;
                    default:    state_d = StHalt;
                endcase
            end
            StMemAdr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
            StMemRd:  if (ready) state_d = StMemWb;
            StMemWr: begin
                if (ready) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end
            end
            StExec:   state_d = StRwb;
            StAddiEx: state_d = StAddiWb;
            StMemWb, StRwb, StBranch, StJump, StAddiWb: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StHalt:   state_d = StHalt;
            default:  state_d = StFetch;
        endcase
    end

    mc_out_decode u_out_decode (
        .state     (state_q),
        .mem_ready (ready),
        .ctrl      (ctrl_raw)
    );

    // Reset must silence FETCH's strobes too, not just restore the state.
    assign ctrl = rst ? '0 : ctrl_raw;

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign iord          = ctrl.iord;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_src        = ctrl.pc_src;
    assign halted        = ctrl.halted;
    assign state_dbg     = state_q;
    assign instr_count   = count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a per-cycle vector table plus hand-written
// sequences for halt, asynchronous reset and counter wrap.
module tb_multicycle_ctrl;
    import mc_pkg::*;

    // {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
    //  reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src, halted}
    localparam logic [16:0] W_ZERO   = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] W_FETCH  = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [16:0] W_FSTALL = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] W_DECODE = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] W_MEMADR = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] W_MEMRD  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] W_MEMWB  = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] W_MEMWR  = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] W_EXEC   = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] W_RWB    = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] W_BRANCH = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] W_JUMP   = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [16:0] W_ADDIEX = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] W_ADDIWB = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
    localparam logic [16:0] W_HALT   = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_1;
    localparam logic [5:0]  OP_BAD   = 6'b111111;

    logic        clk, rst, zf, mem_ready;
    logic [5:0]  opcode;
    logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a, halted;
    logic [1:0]  alu_src_b, alu_op, pc_src;
    logic [3:0]  state_dbg;
    logic [15:0] instr_count;
    logic [16:0] ctl_w;

    logic        unused_pw4, unused_pwc4, unused_iord4, unused_mr4, unused_mw4, unused_irw4;
    logic        unused_m2r4, unused_rdst4, unused_rw4, unused_asa4, unused_halt4;
    logic [1:0]  unused_asb4, unused_aop4, unused_psrc4;
    logic [3:0]  unused_st4;
    logic [3:0]  count4;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       nm;
        logic [5:0]  op;
        logic        zf;
        logic        rdy;
        logic [3:0]  st;
        logic [16:0] w;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zf(zf), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .halted(halted), .state_dbg(state_dbg), .instr_count(instr_count)
    );

    multicycle_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .opcode(opcode), .zf(zf), .mem_ready(mem_ready),
        .pc_write(unused_pw4), .pc_write_cond(unused_pwc4), .iord(unused_iord4),
        .mem_read(unused_mr4), .mem_write(unused_mw4), .ir_write(unused_irw4),
        .mem_to_reg(unused_m2r4), .reg_dst(unused_rdst4), .reg_write(unused_rw4),
        .alu_src_a(unused_asa4), .alu_src_b(unused_asb4), .alu_op(unused_aop4),
        .pc_src(unused_psrc4), .halted(unused_halt4), .state_dbg(unused_st4),
        .instr_count(count4)
    );

    assign ctl_w = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
                    reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src, halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [3:0] est, input logic [16:0] ew,
                       input logic [15:0] ecnt);
        n_checks++;
        if (state_dbg !== est) begin
            n_fail++;
            $display("FAIL %s state_dbg got=%0d exp=%0d", nm, state_dbg, est);
        end
        n_checks++;
        if (ctl_w !== ew) begin
            n_fail++;
            $display("FAIL %s ctrl got=%b exp=%b", nm, ctl_w, ew);
        end
        n_checks++;
        if (instr_count !== ecnt) begin
            n_fail++;
            $display("FAIL %s instr_count got=%0d exp=%0d", nm, instr_count, ecnt);
        end
    endtask

    task automatic chk4(input string nm, input logic [3:0] ecnt);
        n_checks++;
        if (count4 !== ecnt) begin
            n_fail++;
            $display("FAIL %s cnt4 got=%0d exp=%0d", nm, count4, ecnt);
        end
    endtask

    function automatic void add(input string nm, input logic [5:0] op, input logic z,
                                input logic rdy, input state_e st, input logic [16:0] w,
                                input logic [15:0] cnt);
        vec_t v;
        v.nm = nm; v.op = op; v.zf = z; v.rdy = rdy; v.st = st; v.w = w; v.cnt = cnt;
        tbl.push_back(v);
    endfunction

    // Drive inputs, check the current state's outputs, then move to the next low phase.
    task automatic step(input string nm, input logic [5:0] op, input logic z, input logic rdy,
                        input logic [3:0] st, input logic [16:0] w, input logic [15:0] cnt);
        opcode = op; zf = z; mem_ready = rdy;
        #1;
        chk(nm, st, w, cnt);
        @(negedge clk);
    endtask

    initial begin
        add("r_fetch",   OpR,    1'b0, 1'b1, StFetch,  W_FETCH,  16'd0);
        add("r_dec",     OpR,    1'b0, 1'b1, StDecode, W_DECODE, 16'd0);
        add("r_exec",    OpR,    1'b0, 1'b1, StExec,   W_EXEC,   16'd0);
        add("r_wb",      OpR,    1'b0, 1'b1, StRwb,    W_RWB,    16'd0);
        add("addi_fet",  OpAddi, 1'b0, 1'b1, StFetch,  W_FETCH,  16'd1);
        add("addi_dec",  OpAddi, 1'b0, 1'b1, StDecode, W_DECODE, 16'd1);
        add("addi_ex",   OpAddi, 1'b0, 1'b1, StAddiEx, W_ADDIEX, 16'd1);
        add("addi_wb",   OpAddi, 1'b0, 1'b1, StAddiWb, W_ADDIWB, 16'd1);
        add("sw_fet",    OpSw,   1'b0, 1'b1, StFetch,  W_FETCH,  16'd2);
        add("sw_dec",    OpSw,   1'b0, 1'b1, StDecode, W_DECODE, 16'd2);
        add("sw_adr",    OpSw,   1'b0, 1'b1, StMemAdr, W_MEMADR, 16'd2);
        add("sw_wr",     OpSw,   1'b0, 1'b1, StMemWr,  W_MEMWR,  16'd2);
        add("beq1_fet",  OpBeq,  1'b1, 1'b1, StFetch,  W_FETCH,  16'd3);
        add("beq1_dec",  OpBeq,  1'b1, 1'b1, StDecode, W_DECODE, 16'd3);
        add("beq1_br",   OpBeq,  1'b1, 1'b1, StBranch, W_BRANCH, 16'd3);
        add("beq0_fet",  OpBeq,  1'b0, 1'b1, StFetch,  W_FETCH,  16'd4);
        add("beq0_dec",  OpBeq,  1'b0, 1'b1, StDecode, W_DECODE, 16'd4);
        add("beq0_br",   OpBeq,  1'b0, 1'b1, StBranch, W_BRANCH, 16'd4);
        add("lw_fstall", OpLw,   1'b0, 1'b0, StFetch,  W_FSTALL, 16'd5);
        add("lw_fet",    OpLw,   1'b0, 1'b1, StFetch,  W_FETCH,  16'd5);
        add("lw_dec",    OpLw,   1'b0, 1'b0, StDecode, W_DECODE, 16'd5);
        add("lw_adr",    OpLw,   1'b0, 1'b1, StMemAdr, W_MEMADR, 16'd5);
        add("lw_rd0",    OpLw,   1'b0, 1'b0, StMemRd,  W_MEMRD,  16'd5);
        add("lw_rd1",    OpLw,   1'b0, 1'b0, StMemRd,  W_MEMRD,  16'd5);
        add("lw_rd2",    OpLw,   1'b0, 1'b0, StMemRd,  W_MEMRD,  16'd5);
        add("lw_rd3",    OpLw,   1'b0, 1'b1, StMemRd,  W_MEMRD,  16'd5);
        add("lw_wb",     OpLw,   1'b0, 1'b0, StMemWb,  W_MEMWB,  16'd5);

        rst = 1'b1; opcode = OpR; zf = 1'b0; mem_ready = 1'b1;
        #1;
        chk("reset", StFetch, W_ZERO, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].nm, tbl[i].op, tbl[i].zf, tbl[i].rdy, tbl[i].st, tbl[i].w, tbl[i].cnt);
        end

        // Illegal opcode: halt, ignore mem_ready, freeze the counter.
        step("bad_fet", OP_BAD, 1'b0, 1'b1, StFetch, W_FETCH, 16'd6);
        step("bad_dec", OP_BAD, 1'b0, 1'b1, StDecode, W_DECODE, 16'd6);
        for (int i = 0; i < 20; i++) begin
            step("halt", OP_BAD, 1'b0, i[0], StHalt, W_HALT, 16'd6);
        end
        #3 rst = 1'b1;
        #1;
        chk("halt_rst", StFetch, W_ZERO, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset dropped into the middle of a stalled store.
        step("sw2_fet", OpSw, 1'b0, 1'b1, StFetch, W_FETCH, 16'd0);
        step("sw2_dec", OpSw, 1'b0, 1'b1, StDecode, W_DECODE, 16'd0);
        step("sw2_adr", OpSw, 1'b0, 1'b1, StMemAdr, W_MEMADR, 16'd0);
        mem_ready = 1'b0;
        #1;
        chk("sw2_wr", StMemWr, W_MEMWR, 16'd0);
        #2 rst = 1'b1;
        #1;
        chk("sw2_async", StFetch, W_ZERO, 16'd0);
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("sw2_inrst", StFetch, W_ZERO, 16'd0);
        rst = 1'b0;
        #1;
        chk("sw2_rel", StFetch, W_FETCH, 16'd0);
        @(negedge clk);
        step("sw2_dec2", OpSw, 1'b0, 1'b1, StDecode, W_DECODE, 16'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Sixteen jumps: 16-bit count reaches 16, 4-bit count wraps to 0.
        for (int i = 0; i < 16; i++) begin
            chk4("j_cnt4", i[3:0]);
            step("j_fet", OpJ, 1'b0, 1'b1, StFetch, W_FETCH, 16'(i));
            step("j_dec", OpJ, 1'b0, 1'b1, StDecode, W_DECODE, 16'(i));
            step("j_jump", OpJ, 1'b0, 1'b1, StJump, W_JUMP, 16'(i));
        end
        opcode = OpJ;
        #1;
        chk("j_end", StFetch, W_FETCH, 16'd16);
        chk4("j_wrap", 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
